// File: rtl/int_vector_ctrl.sv
// Interrupt vectoring controller: holds the arbiter's request until an instruction
// boundary, runs the req/ack handshake to the CPU and tracks in-service state until RETI.
// Optional two-level nesting with IP priority bits: define INT_NEST_EN.
module int_vector_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int unsigned VEC_STRIDE = 8,
    parameter int unsigned NUM_SRC    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] int_early,
    input  logic               instr_end,
    input  logic               int_ack,
    input  logic               reti,
`ifdef INT_NEST_EN
    input  logic [NUM_SRC-1:0] IP,
`endif
    output logic               int_req,
    output logic [15:0]        int_vec,
    output logic [NUM_SRC-1:0] clr_flag,
    output logic               in_service
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, PEND, REQ, SERV} state_t;

    state_t             state;
    logic               block;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_SRC-1:0] cand;
    logic [IDX_W-1:0]   sel_idx;
    logic [15:0]        sel_vec;
    logic [NUM_SRC-1:0] idx_onehot;

`ifdef INT_NEST_EN
    logic               lo_active;
    logic               hi_active;
    logic [IDX_W-1:0]   lo_idx;
    logic [NUM_SRC-1:0] hi_req;
`endif

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        lowest_idx = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--)
            if (v[i-1]) lowest_idx = IDX_W'(i - 1);
    endfunction

    // While a low-priority handler runs, only high-priority sources may preempt it.
    always_comb begin
`ifdef INT_NEST_EN
        hi_req = int_early & IP;
        if (lo_active)
            cand = hi_req;
        else
            cand = (|hi_req) ? hi_req : int_early;
`else
        cand = int_early;
`endif
    end

    assign sel_idx    = lowest_idx(cand);
    assign sel_vec    = VEC_BASE + 16'(VEC_STRIDE * 32'(sel_idx));
    assign idx_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            block      <= 1'b0;
            idx_q      <= '0;
            int_req    <= 1'b0;
            int_vec    <= '0;
            clr_flag   <= '0;
            in_service <= 1'b0;
`ifdef INT_NEST_EN
            lo_active  <= 1'b0;
            hi_active  <= 1'b0;
            lo_idx     <= '0;
`endif
        end else begin
            clr_flag <= '0;
            // Any instr_end releases the post-RETI block; a RETI in the same cycle re-sets it below.
            if (instr_end) block <= 1'b0;

            case (state)
                IDLE: begin
                    if (|cand && !block) begin
                        idx_q <= sel_idx;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (cand == '0) begin
`ifdef INT_NEST_EN
                        state <= lo_active ? SERV : IDLE;
`else
                        state <= IDLE;
`endif
                    end else begin
                        idx_q <= sel_idx;
                        if (instr_end) begin
                            int_req <= 1'b1;
                            int_vec <= sel_vec;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERV;
                        if (32'(idx_q) < 32'd4) clr_flag <= idx_onehot;
`ifdef INT_NEST_EN
                        if (lo_active) hi_active <= 1'b1;
                        else           lo_active <= 1'b1;
`endif
                    end
                end
                SERV: begin
`ifdef INT_NEST_EN
                    if (reti) begin
                        block <= 1'b1;
                        if (hi_active) begin
                            hi_active <= 1'b0;
                            idx_q     <= lo_idx;
                        end else begin
                            lo_active  <= 1'b0;
                            in_service <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (!hi_active && |hi_req && !block) begin
                        lo_idx <= idx_q;
                        idx_q  <= sel_idx;
                        state  <= PEND;
                    end
`else
                    if (reti) begin
                        in_service <= 1'b0;
                        block      <= 1'b1;
                        state      <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Self-checking bench for int_vector_ctrl: directed vector table, reset/hold sequences,
// then randomized traffic against a behavioural reference model.
module tb_int_vector_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  int_early = '0;
    logic        instr_end = 1'b0;
    logic        int_ack = 1'b0;
    logic        reti = 1'b0;
`ifdef INT_NEST_EN
    logic [4:0]  ip = '0;
`endif
    logic        int_req;
    logic [15:0] int_vec;
    logic [4:0]  clr_flag;
    logic        in_service;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_vector_ctrl #(
        .VEC_BASE   (16'h0003),
        .VEC_STRIDE (8),
        .NUM_SRC    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_early  (int_early),
        .instr_end  (instr_end),
        .int_ack    (int_ack),
        .reti       (reti),
`ifdef INT_NEST_EN
        .IP         (ip),
`endif
        .int_req    (int_req),
        .int_vec    (int_vec),
        .clr_flag   (clr_flag),
        .in_service (in_service)
    );

    typedef struct {
        logic [4:0]  early;
        logic        ie;
        logic        ack;
        logic        rt;
        logic        req;
        logic [15:0] vec;
        logic [4:0]  clr;
        logic        serv;
    } row_t;

    row_t tbl[$];

    // Reference model: which phase of the interrupt life cycle we are in.
    bit         m_pend, m_req, m_serv, m_block;
    logic [15:0] m_vec;
    logic [4:0]  m_clr;
    int          m_req_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic rq, input logic [15:0] v,
                             input logic [4:0] c, input logic sv);
        check({tag, ".int_req"},    32'(int_req),    32'(rq));
        check({tag, ".int_vec"},    32'(int_vec),    32'(v));
        check({tag, ".clr_flag"},   32'(clr_flag),   32'(c));
        check({tag, ".in_service"}, 32'(in_service), 32'(sv));
    endtask

    task automatic add(input logic [4:0] e, input logic ie, input logic ack, input logic rt,
                       input logic rq, input logic [15:0] v, input logic [4:0] c, input logic sv);
        row_t r;
        r.early = e; r.ie = ie; r.ack = ack; r.rt = rt;
        r.req = rq; r.vec = v; r.clr = c; r.serv = sv;
        tbl.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pend = 0; m_req = 0; m_serv = 0; m_block = 0;
        m_vec = '0; m_clr = '0; m_req_idx = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int idx;
        idx = 0;
        for (int b = 4; b >= 0; b--)
            if (int_early[b]) idx = b;
        m_clr = '0;
        if (m_req) begin
            if (int_ack) begin
                m_req  = 0;
                m_serv = 1;
                if (m_req_idx < 4) m_clr = 5'(1 << m_req_idx);
            end
        end else if (m_serv) begin
            if (reti) begin
                m_serv  = 0;
                m_block = 1;
            end
        end else if (m_pend) begin
            if (int_early == '0) m_pend = 0;
            else if (instr_end) begin
                m_pend    = 0;
                m_req     = 1;
                m_vec     = 16'h0003 + 16'(idx * 8);
                m_req_idx = idx;
            end
        end else begin
            if (m_block) begin
                if (instr_end) m_block = 0;
            end else if (int_early != '0) begin
                m_pend = 1;
            end
        end
    endtask

    initial begin
        // early   ie ack rt | req vec      clr      serv
        add(5'b00001, 0, 0, 0,  0, 16'h0000, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  0, 16'h0000, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  0, 16'h0000, 5'b00000, 0);
        add(5'b00001, 1, 0, 0,  1, 16'h0003, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  1, 16'h0003, 5'b00000, 0);
        add(5'b00001, 0, 1, 0,  0, 16'h0003, 5'b00001, 1);
        add(5'b00001, 0, 0, 0,  0, 16'h0003, 5'b00000, 1);
        add(5'b00000, 0, 0, 1,  0, 16'h0003, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0003, 5'b00000, 0);
        add(5'b10100, 0, 0, 0,  0, 16'h0003, 5'b00000, 0);
        add(5'b10100, 1, 0, 0,  1, 16'h0013, 5'b00000, 0);
        add(5'b10100, 0, 1, 0,  0, 16'h0013, 5'b00100, 1);
        add(5'b00000, 0, 0, 1,  0, 16'h0013, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0013, 5'b00000, 0);
        add(5'b10000, 0, 0, 0,  0, 16'h0013, 5'b00000, 0);
        add(5'b10000, 1, 0, 0,  1, 16'h0023, 5'b00000, 0);
        add(5'b10000, 0, 1, 0,  0, 16'h0023, 5'b00000, 1);
        add(5'b00000, 0, 0, 1,  0, 16'h0023, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00010, 0, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00000, 0, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  0, 16'h0023, 5'b00000, 0);
        add(5'b00001, 1, 0, 0,  1, 16'h0003, 5'b00000, 0);
        add(5'b00001, 0, 1, 0,  0, 16'h0003, 5'b00001, 1);
        add(5'b00010, 0, 0, 0,  0, 16'h0003, 5'b00000, 1);
        add(5'b00010, 0, 0, 1,  0, 16'h0003, 5'b00000, 0);
        add(5'b00010, 1, 0, 0,  0, 16'h0003, 5'b00000, 0);
        add(5'b00010, 0, 0, 0,  0, 16'h0003, 5'b00000, 0);
        add(5'b00010, 1, 0, 0,  1, 16'h000B, 5'b00000, 0);
        add(5'b00010, 0, 1, 0,  0, 16'h000B, 5'b00010, 1);
        add(5'b00000, 0, 0, 1,  0, 16'h000B, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h000B, 5'b00000, 0);
        add(5'b00000, 0, 1, 1,  0, 16'h000B, 5'b00000, 0);
        add(5'b00100, 0, 0, 0,  0, 16'h000B, 5'b00000, 0);
        add(5'b00100, 1, 0, 0,  1, 16'h0013, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  1, 16'h0013, 5'b00000, 0);
        add(5'b00001, 0, 1, 0,  0, 16'h0013, 5'b00100, 1);
        add(5'b00001, 1, 0, 1,  0, 16'h0013, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  0, 16'h0013, 5'b00000, 0);
        add(5'b00001, 1, 0, 0,  0, 16'h0013, 5'b00000, 0);
        add(5'b00001, 0, 0, 0,  0, 16'h0013, 5'b00000, 0);
        add(5'b00001, 1, 0, 0,  1, 16'h0003, 5'b00000, 0);
        add(5'b00001, 0, 1, 0,  0, 16'h0003, 5'b00001, 1);
        add(5'b00000, 0, 0, 1,  0, 16'h0003, 5'b00000, 0);
        add(5'b00000, 1, 0, 0,  0, 16'h0003, 5'b00000, 0);

        // Reset state, sampled after the first clock edge under reset.
        #7;
        check_all("reset", 1'b0, 16'h0000, 5'b00000, 1'b0);
        #5 rst_n = 1'b1;

        foreach (tbl[i]) begin
            int_early = tbl[i].early;
            instr_end = tbl[i].ie;
            int_ack   = tbl[i].ack;
            reti      = tbl[i].rt;
            tick();
            check_all($sformatf("row%0d", i), tbl[i].req, tbl[i].vec, tbl[i].clr, tbl[i].serv);
        end
        int_early = '0; instr_end = 0; int_ack = 0; reti = 0;

        // Reset in the middle of a handshake, then the held request is re-taken from IDLE.
        int_early = 5'b00001;
        tick();
        instr_end = 1;
        tick();
        instr_end = 0;
        check_all("rst_pre", 1'b1, 16'h0003, 5'b00000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all("rst_async", 1'b0, 16'h0000, 5'b00000, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check_all("rst_idle", 1'b0, 16'h0000, 5'b00000, 1'b0);
        instr_end = 1;
        tick();
        instr_end = 0;
        check_all("rst_retake", 1'b1, 16'h0003, 5'b00000, 1'b0);

        // No timeout: request holds while int_early wanders and no ack arrives.
        for (int k = 0; k < 20; k++) begin
            int_early = 5'($urandom);
            instr_end = 1'($urandom);
            tick();
            check_all("hold", 1'b1, 16'h0003, 5'b00000, 1'b0);
        end
        instr_end = 0;
        int_ack = 1;
        tick();
        int_ack = 0;
        check_all("hold_ack", 1'b0, 16'h0003, 5'b00001, 1'b1);

        // Fresh start for randomized traffic.
        int_early = '0;
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
        model_reset();

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0)
                int_early = ($urandom_range(0, 2) == 0) ? 5'b00000 : 5'($urandom);
            instr_end = ($urandom_range(0, 2) == 0);
            int_ack   = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            reti      = m_serv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            model_step();
            tick();
            check_all("rand", m_req, m_vec, m_clr, m_serv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
